iiitb_mem_arbiter: RTL
======================

// Module: iiitb_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the RV32I fetch stage (IF port) and the
//  MEM stage (DM port). Non-pipelined: one access in flight. Data port has priority;
//  a starvation guard forces a fetch grant after MAX_WAIT lost cycles.
//  Sits between the pipeline stage registers and the unified IMEM/DMEM array.
// PARAMETERS
//  AW       5   address width (words)
//  DW       32  data width
//  MEM_LAT  1   cycles from mem_en to valid mem_rdata (>=1)
//  MAX_WAIT 4   lost cycles before fetch is forced to win (>=1)
// PORTS
//  clk       in   1   clock, all logic on posedge
//  RN        in   1   reset: one clock; synchronous, active-high
//  if_req    in   1   fetch read request; hold with if_addr until if_gnt
//  if_addr   in   AW  fetch word address
//  if_gnt    out  1   1-cycle pulse: fetch accepted
//  if_rvalid out  1   1-cycle pulse: if_rdata valid
//  if_rdata  out  DW  fetched instruction
//  dm_req    in   1   data request; hold dm_we/addr/wdata until dm_gnt
//  dm_we     in   1   1=store, 0=load
//  dm_addr   in   AW  data word address
//  dm_wdata  in   DW  store data
//  dm_gnt    out  1   1-cycle pulse: data access accepted
//  dm_rvalid out  1   1-cycle pulse: dm_rdata valid (loads only)
//  dm_rdata  out  DW  load data
//  mem_en    out  1   memory access strobe, high 1 cycle
//  mem_we    out  1   memory write enable, qualified by mem_en
//  mem_addr  out  AW  memory address
//  mem_wdata out  DW  memory write data
//  mem_rdata in   DW  memory read data, valid MEM_LAT cycles after mem_en
//  busy      out  1   1 when state != IDLE
// BEHAVIOUR
//  - All outputs registered. RN=1 at posedge: state=IDLE, all outputs 0, lat_cnt=0,
//    wait_cnt=0; any in-flight read discarded (no rvalid ever issued for it).
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: sample reqs at posedge; if any req, register gnt of winner, mem_en=1,
//      mem_we/addr/wdata from winner, lat_cnt=MEM_LAT, -> WAIT. Else stay.
//    WAIT: lat_cnt decrements; at lat_cnt==1 capture mem_rdata -> RESP.
//    RESP: rvalid=1 plus rdata for winner if read; stores give no rvalid; -> IDLE.
//  - Timing: req seen at edge k -> gnt/mem_en in cycle k+1 -> rvalid in cycle
//    k+2+MEM_LAT. Back-to-back throughput: one access per MEM_LAT+2 cycles.
//  - Requests are sampled only in IDLE; a req dropped before its gnt is not served.
//    Requester must drop or change req on the edge ending its gnt cycle.
//  - Arbitration (both req in IDLE): dm wins unless wait_cnt>=MAX_WAIT, then if wins.
//  - wait_cnt: +1 each IDLE decision where if_req=1 and if loses, saturating at
//    MAX_WAIT; cleared on if grant or when if_req=0 in IDLE.
//    Width = $clog2(MAX_WAIT+1).
//  - Winner id latched at grant; rdata is routed only to that port, the other
//    port's rdata holds its last value.
// CONFIGURATION
//  IIITB_ARB_RR_EN defined: fixed priority and wait_cnt removed; strict round-robin,
//    last-granted port loses ties (last_gnt resets to IF, so dm wins first tie).
//  Undefined: dm priority with starvation guard as above. Ports identical.
// STRUCTURE
//  iiitb_rv32i_pkg: FSM state enum {IDLE,WAIT,RESP}, port id constants
//    PORT_IF=1'b0 / PORT_DM=1'b1.
//  Sub-module iiitb_starve_cnt: saturating wait counter with clear, MAX_WAIT param;
//    not instantiated under IIITB_ARB_RR_EN.
// TESTING
//  1 RN=1 mid-WAIT of load, mem_rdata=32'hDEAD -> all outputs 0 next cycle,
//    no dm_rvalid, busy=0.
//  2 if_req only, addr 3, mem_rdata=32'h02208300, MEM_LAT=1 -> if_gnt cycle 1,
//    mem_addr=3, if_rvalid cycle 3 with if_rdata=32'h02208300.
//  3 dm store addr 2 data 32'd3 -> dm_gnt, mem_en=1, mem_we=1, mem_wdata=3;
//    no dm_rvalid; busy low after MEM_LAT+2 cycles.
//  4 if_req and dm_req held high continuously, MAX_WAIT=4 -> grants DM,DM,DM,DM,IF
//    repeating; with IIITB_ARB_RR_EN -> DM,IF,DM,IF.
//  5 MEM_LAT=3 load addr 8, mem_rdata=32'd7 three cycles after mem_en ->
//    dm_rvalid in cycle k+5, dm_rdata=7, if_rdata unchanged.
//  6 if_req pulsed 1 cycle during WAIT -> never granted, wait_cnt stays 0.

Source files
------------

// File: rtl/iiitb_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// iiitb_rv32i_pkg : shared FSM state encoding and port ids for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iiitb_rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/iiitb_mem_arbiter_starve_cnt.sv
// ---------------------------------------------------------------------------
// iiitb_starve_cnt : saturating count of fetch-lost decisions, with clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iiitb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int            CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q < MAX_C))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q >= MAX_C);

endmodule

`default_nettype wire

// File: rtl/iiitb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iiitb_mem_arbiter : IF/DM arbiter for one single-port memory, one access in
// flight. Option macro: IIITB_ARB_RR_EN (round-robin instead of DM priority).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iiitb_mem_arbiter
  import iiitb_rv32i_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          RN_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int LW = $clog2(MEM_LAT + 1);

  arb_state_e    state_q;
  logic [LW-1:0] lat_cnt_q;
  logic          win_q;
  logic [DW-1:0] rdata_q;
  logic          any_req;
  logic          win_dm;
  logic          idle;

  assign any_req = if_req_i | dm_req_i;
  assign idle    = (state_q == IDLE);

`ifdef IIITB_ARB_RR_EN
  logic last_gnt_q;

  // On a tie the port granted last time loses.
  assign win_dm = dm_req_i & (~if_req_i | (last_gnt_q == PORT_IF));
`else
  logic if_forced;

  assign win_dm = dm_req_i & ~(if_req_i & if_forced);

  iiitb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (RN_i),
    .inc_i (idle & if_req_i & win_dm),
    .clr_i (idle & ~(if_req_i & win_dm)),
    .sat_o (if_forced)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (RN_i) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      win_q       <= PORT_IF;
      rdata_q     <= '0;
      if_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dm_gnt_o    <= 1'b0;
      dm_rvalid_o <= 1'b0;
      dm_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
`ifdef IIITB_ARB_RR_EN
      last_gnt_q  <= PORT_IF;
`endif
    end else begin
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      mem_en_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q       <= win_dm;
            if_gnt_o    <= ~win_dm;
            dm_gnt_o    <= win_dm;
            mem_en_o    <= 1'b1;
            mem_we_o    <= win_dm & dm_we_i;
            mem_addr_o  <= win_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= win_dm ? dm_wdata_i : '0;
            lat_cnt_q   <= LW'(MEM_LAT);
            busy_o      <= 1'b1;
            state_q     <= WAIT;
`ifdef IIITB_ARB_RR_EN
            last_gnt_q  <= win_dm;
`endif
          end
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - LW'(1);
          if (lat_cnt_q == LW'(1)) begin
            rdata_q <= mem_rdata_i;
            state_q <= RESP;
          end
        end
        RESP: begin
          // mem_we_o is held from the grant, so it still tells load from store.
          if (!mem_we_o) begin
            if (win_q == PORT_DM) begin
              dm_rvalid_o <= 1'b1;
              dm_rdata_o  <= rdata_q;
            end else begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= rdata_q;
            end
          end
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
